// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the I/D memory port arbiter: FSM states
//               and transaction owner.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin pick between fetch and data requests.
//               On a tie the requester that did not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_req_i,
  input  logic   i_req_d,
  input  owner_t i_last,
  output logic   o_valid,
  output owner_t o_owner
);

  // Pick a winner; o_owner is only meaningful while o_valid is high
  always_comb begin
    o_valid = i_req_i | i_req_d;
    o_owner = OWN_D;
    if (i_req_i && i_req_d) begin
      o_owner = (i_last == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req_i) begin
      o_owner = OWN_I;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-ported unified memory between the fetch (I)
//               and load/store (D) sides. Round-robin grant, one outstanding
//               memory transaction, fetch flush squashes the I response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DWIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // fetch side
  input  logic              i_ireq,
  input  logic [WIDTH-1:0]  i_iaddr,
  input  logic              i_iflush,
  output logic              o_igrant,
  output logic              o_ivalid,
  output logic [DWIDTH-1:0] o_idata,
  // load/store side
  input  logic              i_dreq,
  input  logic [WIDTH-1:0]  i_daddr,
  input  logic              i_dwe,
  input  logic [DWIDTH-1:0] i_dwdata,
  output logic              o_dgrant,
  output logic              o_dvalid,
  output logic [DWIDTH-1:0] o_ddata,
  // memory side
  output logic              o_mreq,
  output logic [WIDTH-1:0]  o_maddr,
  output logic              o_mwe,
  output logic [DWIDTH-1:0] o_mwdata,
  input  logic              i_mack,
  input  logic [DWIDTH-1:0] i_mrdata
);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              r_last;
  logic                r_mreq;
  logic [WIDTH-1:0]    r_maddr;
  logic                r_mwe;
  logic [DWIDTH-1:0]   r_mwdata;
  logic                r_kill;
  logic                r_ivalid;
  logic [DWIDTH-1:0]   r_idata;
  logic                r_dvalid;
  logic [DWIDTH-1:0]   r_ddata;

  logic                w_ireq_eff;
  logic                w_pick_valid;
  owner_t              w_pick_owner;
  logic                w_grant;
  logic                w_ack;

  // A flush in the same cycle masks the fetch request
  assign w_ireq_eff = i_ireq & ~i_iflush;

  rr_arbiter2 u_rr (
    .i_req_i (w_ireq_eff),
    .i_req_d (i_dreq),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_owner (w_pick_owner)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and combinational grants; an ack in the mreq cycle is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ack       = 1'b0;
    o_igrant    = 1'b0;
    o_dgrant    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant     = 1'b1;
          o_igrant    = (w_pick_owner == OWN_I);
          o_dgrant    = (w_pick_owner == OWN_D);
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_mack && !r_mreq) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the granted request and issue a one-cycle memory request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner  <= OWN_I;
      r_last   <= OWN_D;
      r_mreq   <= 1'b0;
      r_maddr  <= '0;
      r_mwe    <= 1'b0;
      r_mwdata <= '0;
    end else begin
      r_mreq <= w_grant;
      if (w_grant) begin
        r_owner <= w_pick_owner;
        r_last  <= w_pick_owner;
        if (w_pick_owner == OWN_I) begin
          r_maddr  <= i_iaddr;
          r_mwe    <= 1'b0;
          r_mwdata <= '0;
        end else begin
          r_maddr  <= i_daddr;
          r_mwe    <= i_dwe;
          r_mwdata <= i_dwe ? i_dwdata : '0;
        end
      end
    end
  end

  // Sticky squash of an in-flight fetch, cleared when the transaction ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kill <= 1'b0;
    end else if (w_ack) begin
      r_kill <= 1'b0;
    end else if (r_state == ST_BUSY && r_owner == OWN_I && i_iflush) begin
      r_kill <= 1'b1;
    end
  end

  // Registered response to the owner; data outputs hold their last value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ivalid <= 1'b0;
      r_idata  <= '0;
      r_dvalid <= 1'b0;
      r_ddata  <= '0;
    end else begin
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      if (w_ack && r_owner == OWN_I && !(r_kill || i_iflush)) begin
        r_ivalid <= 1'b1;
        r_idata  <= i_mrdata;
      end
      if (w_ack && r_owner == OWN_D) begin
        r_dvalid <= 1'b1;
        r_ddata  <= r_mwe ? '0 : i_mrdata;
      end
    end
  end

  assign o_mreq   = r_mreq;
  assign o_maddr  = r_maddr;
  assign o_mwe    = r_mwe;
  assign o_mwdata = r_mwdata;
  assign o_ivalid = r_ivalid;
  assign o_idata  = r_idata;
  assign o_dvalid = r_dvalid;
  assign o_ddata  = r_ddata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int WIDTH  = 12;
  localparam int DWIDTH = 32;

  logic              clk;
  logic              rst_n;
  logic              ireq, iflush, igrant, ivalid;
  logic [WIDTH-1:0]  iaddr;
  logic [DWIDTH-1:0] idata;
  logic              dreq, dwe, dgrant, dvalid;
  logic [WIDTH-1:0]  daddr;
  logic [DWIDTH-1:0] dwdata, ddata;
  logic              mreq, mwe, mack;
  logic [WIDTH-1:0]  maddr;
  logic [DWIDTH-1:0] mwdata, mrdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_ireq   (ireq),
    .i_iaddr  (iaddr),
    .i_iflush (iflush),
    .o_igrant (igrant),
    .o_ivalid (ivalid),
    .o_idata  (idata),
    .i_dreq   (dreq),
    .i_daddr  (daddr),
    .i_dwe    (dwe),
    .i_dwdata (dwdata),
    .o_dgrant (dgrant),
    .o_dvalid (dvalid),
    .o_ddata  (ddata),
    .o_mreq   (mreq),
    .o_maddr  (maddr),
    .o_mwe    (mwe),
    .o_mwdata (mwdata),
    .i_mack   (mack),
    .i_mrdata (mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " igrant"}, {63'd0, igrant}, 64'd0);
    check({tag, " dgrant"}, {63'd0, dgrant}, 64'd0);
    check({tag, " ivalid"}, {63'd0, ivalid}, 64'd0);
    check({tag, " dvalid"}, {63'd0, dvalid}, 64'd0);
    check({tag, " mreq"},   {63'd0, mreq},   64'd0);
    check({tag, " mwe"},    {63'd0, mwe},    64'd0);
    check({tag, " maddr"},  {52'd0, maddr},  64'd0);
    check({tag, " mwdata"}, {32'd0, mwdata}, 64'd0);
    check({tag, " idata"},  {32'd0, idata},  64'd0);
    check({tag, " ddata"},  {32'd0, ddata},  64'd0);
  endtask

  initial begin
    int n_grants;
    int n_mreq;
    rst_n = 1'b0; ireq = 0; iflush = 0; iaddr = '0;
    dreq = 0; dwe = 0; daddr = '0; dwdata = '0; mack = 0; mrdata = '0;
    #1;
    check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;

    // Both requesters held: grants alternate I,D,I,D starting with I
    for (int k = 0; k < 4; k++) begin
      tick();
      ireq = 1; dreq = 1; iaddr = 12'h020; daddr = 12'h030; dwe = 0; mack = 0;
      #1;
      check("rr igrant", {63'd0, igrant}, (k % 2 == 0) ? 64'd1 : 64'd0);
      check("rr dgrant", {63'd0, dgrant}, (k % 2 == 1) ? 64'd1 : 64'd0);
      check("rr one grant", {63'd0, igrant & dgrant}, 64'd0);
      if (k > 0) begin
        if (k % 2 == 1) check("rr prev idata", {32'd0, idata}, 64'h100 + 64'(k - 1));
        else            check("rr prev ddata", {32'd0, ddata}, 64'h100 + 64'(k - 1));
      end
      tick(); #1;
      check("rr mreq", {63'd0, mreq}, 64'd1);
      check("rr maddr", {52'd0, maddr}, (k % 2 == 0) ? 64'h020 : 64'h030);
      check("rr busy nogrant", {63'd0, igrant | dgrant}, 64'd0);
      tick();
      mack = 1; mrdata = 32'h100 + 32'(k);
    end
    tick();
    ireq = 0; dreq = 0; mack = 0;
    #1;
    check("rr last dvalid", {63'd0, dvalid}, 64'd1);
    check("rr last ddata", {32'd0, ddata}, 64'h103);

    // Only I: grant N, mreq N+1, ack N+2, valid N+3
    tick(); ireq = 1; iaddr = 12'h010; #1;
    check("onlyI igrant", {63'd0, igrant}, 64'd1);
    check("onlyI mreq N", {63'd0, mreq}, 64'd0);
    tick(); ireq = 0; #1;
    check("onlyI mreq N+1", {63'd0, mreq}, 64'd1);
    check("onlyI maddr", {52'd0, maddr}, 64'h010);
    check("onlyI mwe", {63'd0, mwe}, 64'd0);
    tick(); mack = 1; mrdata = 32'h00500093; #1;
    check("onlyI mreq N+2", {63'd0, mreq}, 64'd0);
    check("onlyI ivalid N+2", {63'd0, ivalid}, 64'd0);
    tick(); mack = 0; #1;
    check("onlyI ivalid N+3", {63'd0, ivalid}, 64'd1);
    check("onlyI idata", {32'd0, idata}, 64'h00500093);
    tick(); #1;
    check("onlyI ivalid pulse", {63'd0, ivalid}, 64'd0);

    // Store: memory read data is ignored, ddata returns zero
    tick(); dreq = 1; dwe = 1; daddr = 12'h100; dwdata = 32'hDEADBEEF; #1;
    check("st dgrant", {63'd0, dgrant}, 64'd1);
    tick(); dreq = 0; dwe = 0; #1;
    check("st mreq", {63'd0, mreq}, 64'd1);
    check("st mwe", {63'd0, mwe}, 64'd1);
    check("st maddr", {52'd0, maddr}, 64'h100);
    check("st mwdata", {32'd0, mwdata}, 64'hDEADBEEF);
    tick(); mack = 1; mrdata = 32'hFFFFFFFF;
    tick(); mack = 0; #1;
    check("st dvalid", {63'd0, dvalid}, 64'd1);
    check("st ddata", {32'd0, ddata}, 64'd0);
    check("st ivalid", {63'd0, ivalid}, 64'd0);

    // Flush in IDLE masks the fetch request
    tick(); ireq = 1; iflush = 1; iaddr = 12'h040; #1;
    check("flush idle igrant", {63'd0, igrant}, 64'd0);

    // Flush during BUSY squashes the fetch response
    tick(); iflush = 0; #1;
    check("fl igrant", {63'd0, igrant}, 64'd1);
    tick(); ireq = 0; iflush = 1; dreq = 1; daddr = 12'h050; dwe = 0; #1;
    check("fl mreq", {63'd0, mreq}, 64'd1);
    check("fl busy dgrant", {63'd0, dgrant}, 64'd0);
    tick(); iflush = 0; mack = 1; mrdata = 32'h1234; #1;
    check("fl ack dgrant", {63'd0, dgrant}, 64'd0);
    tick(); mack = 0; #1;
    check("fl ivalid", {63'd0, ivalid}, 64'd0);
    check("fl idata held", {32'd0, idata}, 64'h00500093);
    check("fl dgrant next", {63'd0, dgrant}, 64'd1);
    tick(); dreq = 0; #1;
    check("fl d maddr", {52'd0, maddr}, 64'h050);
    check("fl ivalid later", {63'd0, ivalid}, 64'd0);
    tick(); mack = 1; mrdata = 32'hA5A5A5A5;
    tick(); mack = 0; #1;
    check("fl dvalid", {63'd0, dvalid}, 64'd1);
    check("fl ddata", {32'd0, ddata}, 64'hA5A5A5A5);

    // Slow memory: ack 10 cycles after mreq, both requests held
    tick(); ireq = 1; dreq = 1; iaddr = 12'h060; daddr = 12'h061; #1;
    check("slow igrant", {63'd0, igrant}, 64'd1);
    tick(); #1;
    check("slow mreq", {63'd0, mreq}, 64'd1);
    n_grants = 0; n_mreq = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      mack = (j == 10);
      mrdata = 32'hCAFE0000;
      #1;
      n_grants += int'(igrant) + int'(dgrant);
      n_mreq   += int'(mreq);
    end
    check("slow wait grants", 64'(n_grants), 64'd0);
    check("slow wait mreq", 64'(n_mreq), 64'd0);
    tick(); mack = 0; #1;
    check("slow ivalid", {63'd0, ivalid}, 64'd1);
    check("slow idata", {32'd0, idata}, 64'hCAFE0000);
    check("slow dgrant", {63'd0, dgrant}, 64'd1);

    // Reset while BUSY, then a stray ack
    tick(); ireq = 0; dreq = 0; #1;
    check("rst pre mreq", {63'd0, mreq}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst busy");
    tick(); rst_n = 1'b1;
    tick(); mack = 1; mrdata = 32'h77777777;
    tick(); mack = 0; #1;
    check("rst stray ivalid", {63'd0, ivalid}, 64'd0);
    check("rst stray dvalid", {63'd0, dvalid}, 64'd0);
    check("rst stray mreq", {63'd0, mreq}, 64'd0);
    tick(); ireq = 1; iaddr = 12'h070; #1;
    check("rst next igrant", {63'd0, igrant}, 64'd1);
    tick(); ireq = 0; #1;
    check("rst next maddr", {52'd0, maddr}, 64'h070);
    check("rst next mreq", {63'd0, mreq}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
